// File: rtl/replacement_unit.sv
// Per-set replacement-policy engine: true-LRU age counters or tree-PLRU bits.
// Optional way locking is enabled by defining REPLACEMENT_WAY_LOCK_EN.
module replacement_unit #(
    parameter int NUM_WAYS   = 4,
    parameter int INDEX_BITS = 8,
    parameter int POLICY     = 0,
    localparam int WB        = $clog2(NUM_WAYS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] lookup_index,
    output logic [NUM_WAYS-1:0]   victim,
    output logic [WB-1:0]         victim_way,
    output logic                  victim_valid,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic [WB-1:0]         update_way,
    input  logic                  update_valid,
`ifdef REPLACEMENT_WAY_LOCK_EN
    input  logic [NUM_WAYS-1:0]   lock_mask,
`endif
    output logic                  ready
);

    localparam int SETS = 1 << INDEX_BITS;

    typedef enum logic {INIT, RUN} state_t;

    state_t                state, state_next;
    logic [INDEX_BITS-1:0] count, count_next;
    logic                  init_write;
    logic                  do_update;
    logic [NUM_WAYS-1:0]   avail;
    logic [WB-1:0]         sel_way;
    logic                  sel_any;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INIT;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        init_write = 1'b0;
        if (state == INIT && !reset) begin
            init_write = 1'b1;
            count_next = count + 1'b1;
            if (count == '1)
                state_next = RUN;
        end
    end

    assign ready     = (state == RUN);
    assign do_update = ready & update_valid & ~reset;

`ifdef REPLACEMENT_WAY_LOCK_EN
    assign avail = ~lock_mask;
`else
    assign avail = '1;
`endif

    generate
        if (POLICY == 0) begin : g_lru
            typedef logic [NUM_WAYS-1:0][WB-1:0] row_t;
            row_t age [SETS];
            row_t urow, nrow, irow, lrow;
            logic [WB-1:0] best;

            // Ages younger than the touched way get one older; touched way becomes MRU.
            always_comb begin
                urow = age[update_index];
                nrow = urow;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    irow[w] = WB'(w);
                    if (urow[w] < urow[update_way])
                        nrow[w] = urow[w] + 1'b1;
                end
                nrow[update_way] = '0;
            end

            always_ff @(posedge clock) begin
                if (init_write)
                    age[count] <= irow;
                else if (do_update)
                    age[update_index] <= nrow;
            end

            always_comb begin
                lrow    = age[lookup_index];
                best    = '0;
                sel_way = '0;
                sel_any = 1'b0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (avail[w] && (!sel_any || lrow[w] > best)) begin
                        sel_any = 1'b1;
                        best    = lrow[w];
                        sel_way = WB'(w);
                    end
                end
            end
        end else begin : g_plru
            // Heap-ordered nodes 1..NUM_WAYS-1; bit=1 points at the upper subtree.
            logic [NUM_WAYS-1:1] tree [SETS];
            logic [NUM_WAYS-1:1] urow, nrow, lrow;
            logic [WB-1:0]       unode;
            logic [WB:0]         node;
            logic                b;
            logic                sub_locked;
            int                  prefix;

            always_comb begin
                urow  = tree[update_index];
                nrow  = urow;
                unode = '0;
                for (int l = 0; l < WB; l++) begin
                    unode       = WB'((1 << l) | (int'(update_way) >> (WB - l)));
                    nrow[unode] = ~update_way[WB-1-l];
                end
            end

            always_ff @(posedge clock) begin
                if (init_write)
                    tree[count] <= '1;
                else if (do_update)
                    tree[update_index] <= nrow;
            end

            // Follow pointers, detouring around a pointed subtree that is fully locked.
            always_comb begin
                lrow       = tree[lookup_index];
                node       = (WB+1)'(1);
                b          = 1'b0;
                sub_locked = 1'b0;
                prefix     = 0;
                for (int l = 0; l < WB; l++) begin
                    b          = lrow[node[WB-1:0]];
                    prefix     = int'({node[WB-1:0], b}) - (2 << l);
                    sub_locked = 1'b1;
                    for (int w = 0; w < NUM_WAYS; w++)
                        if ((w >> (WB - 1 - l)) == prefix && avail[w])
                            sub_locked = 1'b0;
                    if (sub_locked)
                        b = ~b;
                    node = {node[WB-1:0], b};
                end
                sel_way = node[WB-1:0];
                sel_any = |avail;
            end
        end
    endgenerate

    assign victim_valid = ready & sel_any;
    assign victim_way   = victim_valid ? sel_way : '0;
    assign victim       = victim_valid ? (NUM_WAYS'(1) << sel_way) : '0;

endmodule
